vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 258 +++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers line/frame timing from hsync/vsync, locks onto
// the expected raster, regenerates display enable and pixel coordinates, and
// captures the colour at a selectable probe coordinate.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_DISPLAY   = 640,
    parameter int V_DISPLAY   = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [5:0] rgb_in,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic       de,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [5:0] rgb_out,
    output logic       locked,
    output logic [9:0] h_period,
    output logic [9:0] v_period,
    output logic [5:0] probe_color,
    output logic       probe_valid,
    output logic [7:0] frame_count,
    output logic       sync_error
);

    localparam logic [9:0] CNT_MAX     = 10'd1023;
    localparam logic [9:0] H_TOTAL_C   = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_C   = 10'(V_TOTAL);
    localparam logic [9:0] H_START_C   = 10'(H_START);
    localparam logic [9:0] V_START_C   = 10'(V_START);
    localparam logic [9:0] H_END_C     = 10'(H_START + H_DISPLAY);
    localparam logic [9:0] V_END_C     = 10'(V_START + V_DISPLAY);
    localparam logic [9:0] H_DISPLAY_C = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISPLAY_C = 10'(V_DISPLAY);
    localparam logic [7:0] LOCK_C      = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    // Counters stick at their maximum instead of wrapping so that a missing
    // sync can never alias back onto a plausible count.
    function automatic logic [9:0] sat_inc(input logic [9:0] value);
        if (value == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = value + 10'd1;
        end
    endfunction

    // Input capture and one cycle of history for edge detection
    logic       hs_r, vs_r, hs_d_r, vs_d_r;
    logic [5:0] rgb_r;
    // Raster measurement
    logic [9:0] h_cnt_r, v_cnt_r, h_period_r, v_period_r;
    logic       h_seen_r, frame_pend_r;
    // Lock tracking
    lock_state_t state_r, state_next_s;
    logic [7:0]  good_cnt_r, good_next_s;
    logic        locked_r, sync_error_r;
    logic [7:0]  frame_count_r;
    // Display and probe outputs
    logic       de_r, probe_valid_r;
    logic [9:0] pix_x_r, pix_y_r;
    logic [5:0] rgb_out_r, probe_color_r;
    // Derived strobes
    logic       hs_edge_s, vs_edge_s, frame_start_s, mismatch_s, active_s, probe_hit_s;
    logic [9:0] h_meas_s, v_meas_s;

    // Register the raw syncs and colour once; everything else uses these copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r   <= 1'b0;
            vs_r   <= 1'b0;
            hs_d_r <= 1'b0;
            vs_d_r <= 1'b0;
            rgb_r  <= 6'd0;
        end else begin
            hs_r   <= hsync_in;
            vs_r   <= vsync_in;
            hs_d_r <= hs_r;
            vs_d_r <= vs_r;
            rgb_r  <= rgb_in;
        end
    end

    // Edge strobes, frame start, measured lengths and lock-loss conditions
    always_comb begin
        hs_edge_s     = hs_r & ~hs_d_r;
        vs_edge_s     = vs_r & ~vs_d_r;
        // A vsync edge coinciding with an hsync edge is taken as arriving first.
        frame_start_s = hs_edge_s & (frame_pend_r | vs_edge_s);
        h_meas_s      = sat_inc(h_cnt_r);
        v_meas_s      = sat_inc(v_cnt_r);
        mismatch_s    = (hs_edge_s && h_seen_r && (h_meas_s != H_TOTAL_C))
                     || (h_cnt_r == H_TOTAL_C)
                     || (frame_start_s && (v_meas_s != V_TOTAL_C))
                     || (v_cnt_r == V_TOTAL_C);
        active_s      = locked_r
                     && (h_cnt_r >= H_START_C) && (h_cnt_r < H_END_C)
                     && (v_cnt_r >= V_START_C) && (v_cnt_r < V_END_C);
        probe_hit_s   = de_r && (pix_x_r == probe_x) && (pix_y_r == probe_y)
                     && (probe_x < H_DISPLAY_C) && (probe_y < V_DISPLAY_C);
    end

    // Horizontal counter and line-length measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r    <= 10'd0;
            h_period_r <= 10'd0;
            h_seen_r   <= 1'b0;
        end else if (hs_edge_s) begin
            h_cnt_r  <= 10'd0;
            h_seen_r <= 1'b1;
            // The first edge after reset has no preceding edge to measure from.
            if (h_seen_r) begin
                h_period_r <= h_meas_s;
            end
        end else begin
            h_cnt_r <= sat_inc(h_cnt_r);
        end
    end

    // Vertical counter, pending-frame flag and frame-length measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_cnt_r      <= 10'd0;
            v_period_r   <= 10'd0;
            frame_pend_r <= 1'b0;
        end else if (frame_start_s) begin
            v_cnt_r      <= 10'd0;
            v_period_r   <= v_meas_s;
            frame_pend_r <= 1'b0;
        end else if (vs_edge_s) begin
            frame_pend_r <= 1'b1;
        end else if (hs_edge_s) begin
            v_cnt_r <= sat_inc(v_cnt_r);
        end
    end

    // Lock FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        good_next_s  = good_cnt_r;
        case (state_r)
            ST_SEARCH: begin
                if (frame_start_s) begin
                    state_next_s = ST_VERIFY;
                    good_next_s  = 8'd0;
                end else begin
                    state_next_s = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (mismatch_s) begin
                    state_next_s = ST_SEARCH;
                    good_next_s  = 8'd0;
                end else if (frame_start_s) begin
                    good_next_s = good_cnt_r + 8'd1;
                    if ((good_cnt_r + 8'd1) >= LOCK_C) begin
                        state_next_s = ST_LOCKED;
                    end else begin
                        state_next_s = ST_VERIFY;
                    end
                end else begin
                    state_next_s = ST_VERIFY;
                end
            end
            ST_LOCKED: begin
                if (mismatch_s) begin
                    state_next_s = ST_SEARCH;
                    good_next_s  = 8'd0;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s = ST_SEARCH;
                good_next_s  = 8'd0;
            end
        endcase
    end

    // Lock FSM state, lock/error flags and locked-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_SEARCH;
            good_cnt_r    <= 8'd0;
            locked_r      <= 1'b0;
            sync_error_r  <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            state_r      <= state_next_s;
            good_cnt_r   <= good_next_s;
            locked_r     <= (state_next_s == ST_LOCKED);
            sync_error_r <= (state_r == ST_LOCKED) && (state_next_s == ST_SEARCH);
            // Held across loss of lock; only reset clears it.
            if (frame_start_s && (state_r == ST_LOCKED)) begin
                frame_count_r <= frame_count_r + 8'd1;
            end
        end
    end

    // Display enable, coordinates and colour, all zero outside the active area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_r      <= 1'b0;
            pix_x_r   <= 10'd0;
            pix_y_r   <= 10'd0;
            rgb_out_r <= 6'd0;
        end else if (active_s) begin
            de_r      <= 1'b1;
            pix_x_r   <= h_cnt_r - H_START_C;
            pix_y_r   <= v_cnt_r - V_START_C;
            rgb_out_r <= rgb_r;
        end else begin
            de_r      <= 1'b0;
            pix_x_r   <= 10'd0;
            pix_y_r   <= 10'd0;
            rgb_out_r <= 6'd0;
        end
    end

    // Capture the colour shown at the probe coordinate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_color_r <= 6'd0;
            probe_valid_r <= 1'b0;
        end else begin
            probe_valid_r <= probe_hit_s;
            if (probe_hit_s) begin
                probe_color_r <= rgb_out_r;
            end
        end
    end

    assign de          = de_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign rgb_out     = rgb_out_r;
    assign locked      = locked_r;
    assign h_period    = h_period_r;
    assign v_period    = v_period_r;
    assign probe_color = probe_color_r;
    assign probe_valid = probe_valid_r;
    assign frame_count = frame_count_r;
    assign sync_error  = sync_error_r;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a reduced raster so that
// hundreds of frames fit in a short run. Active pixels are predicted as the
// stimulus is generated and consumed from a scoreboard when de is seen.
module tb_vga_sync_receiver;

    localparam int HT = 16;
    localparam int VT = 10;
    localparam int HS = 4;
    localparam int VS = 2;
    localparam int HD = 8;
    localparam int VD = 5;
    localparam int LF = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync_in, vsync_in;
    logic [5:0] rgb_in;
    logic [9:0] probe_x, probe_y;
    logic       de, locked, probe_valid, sync_error;
    logic [9:0] pix_x, pix_y, h_period, v_period;
    logic [5:0] rgb_out, probe_color;
    logic [7:0] frame_count;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] c;
    } pix_t;

    pix_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         de_cnt   = 0;
    int         pv_cnt   = 0;
    int         se_cnt   = 0;
    int         se_line  = -1;
    int         gen_line = 0;
    logic [5:0] exp_probe_c = 6'd0;

    vga_sync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .H_DISPLAY(HD), .V_DISPLAY(VD), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y),
        .de(de), .pix_x(pix_x), .pix_y(pix_y), .rgb_out(rgb_out),
        .locked(locked), .h_period(h_period), .v_period(v_period),
        .probe_color(probe_color), .probe_valid(probe_valid),
        .frame_count(frame_count), .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    // Output monitor: consumes predicted pixels, checks blanking, counts pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_error) begin
                se_cnt  = se_cnt + 1;
                se_line = gen_line;
            end
            if (probe_valid) pv_cnt = pv_cnt + 1;
            n_checks = n_checks + 1;
            if (de) begin
                de_cnt = de_cnt + 1;
                if (sb.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_de: got de=1 x=%0d y=%0d, required de=0", pix_x, pix_y);
                end else begin
                    pix_t e;
                    e = sb.pop_front();
                    if ({pix_x, pix_y, rgb_out} !== e) begin
                        n_fail = n_fail + 1;
                        $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                                 pix_x, pix_y, rgb_out, e.x, e.y, e.c);
                    end
                end
            end else if ({pix_x, pix_y, rgb_out} !== 26'd0) begin
                n_fail = n_fail + 1;
                $display("FAIL blank: got x=%0d y=%0d c=%0d with de=0, required all 0", pix_x, pix_y, rgb_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line of stimulus. Sync edge detection takes one register stage more
    // than the colour path, so pixel x carries the colour driven at line
    // position H_START+x+1.
    task automatic run_line(input int l, input int len, input bit drop, input int seed, input bit exp_de);
        for (int p = 0; p < len; p++) begin
            int x;
            int y;
            gen_line = l;
            hsync_in = !drop && (p < 2);
            vsync_in = (l == 0);
            rgb_in   = 6'(p + seed);
            x = p - HS - 1;
            y = l - VS;
            if (exp_de && x >= 0 && x < HD && y >= 0 && y < VD) begin
                sb.push_back({10'(x), 10'(y), rgb_in});
                if (x == int'(probe_x) && y == int'(probe_y)) exp_probe_c = rgb_in;
            end
            tick();
        end
    endtask

    task automatic run_frame(input int seed, input int drop_line, input int long_line, input bit exp_de);
        for (int l = 0; l < VT; l++) begin
            run_line(l, (l == long_line) ? HT + 1 : HT, l == drop_line, seed, exp_de);
        end
    endtask

    task automatic clear_counts();
        de_cnt  = 0;
        pv_cnt  = 0;
        se_cnt  = 0;
        se_line = -1;
    endtask

    task automatic test_reset();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0d, required 0", locked); end
        n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL rst_de: got %0d, required 0", de); end
        n_checks++; if (h_period !== 10'd0) begin n_fail++; $display("FAIL rst_h_period: got %0d, required 0", h_period); end
        n_checks++; if (v_period !== 10'd0) begin n_fail++; $display("FAIL rst_v_period: got %0d, required 0", v_period); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL rst_frame_count: got %0d, required 0", frame_count); end
        n_checks++; if ({probe_color, probe_valid, sync_error} !== 8'd0) begin n_fail++; $display("FAIL rst_probe_err: got %0h, required 0", {probe_color, probe_valid, sync_error}); end
    endtask

    task automatic test_nominal();
        probe_x = 10'(HD - 1);
        probe_y = 10'(VD - 1);
        clear_counts();
        run_frame(0, -1, -1, 1'b0);
        n_checks++; if (h_period !== 10'(HT)) begin n_fail++; $display("FAIL nom_h_period: got %0d, required %0d", h_period, HT); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL nom_locked_f1: got %0d, required 0", locked); end
        run_frame(0, -1, -1, 1'b0);
        n_checks++; if (v_period !== 10'(VT)) begin n_fail++; $display("FAIL nom_v_period: got %0d, required %0d", v_period, VT); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL nom_locked_f2: got %0d, required 0", locked); end
        clear_counts();
        run_line(0, HT, 1'b0, 0, 1'b1);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL nom_lock_at_fs3: got %0d, required 1", locked); end
        for (int l = 1; l < VT; l++) run_line(l, HT, 1'b0, 0, 1'b1);
        n_checks++; if (de_cnt !== HD * VD) begin n_fail++; $display("FAIL nom_de_count: got %0d, required %0d", de_cnt, HD * VD); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL nom_missing_pixels: got %0d left, required 0", sb.size()); end
        n_checks++; if (pv_cnt !== 1) begin n_fail++; $display("FAIL nom_probe_pulses: got %0d, required 1", pv_cnt); end
        n_checks++; if (probe_color !== exp_probe_c) begin n_fail++; $display("FAIL nom_probe_color: got %0d, required %0d", probe_color, exp_probe_c); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL nom_fc0: got %0d, required 0", frame_count); end
        clear_counts();
        run_frame(5, -1, -1, 1'b1);
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL nom_fc1: got %0d, required 1", frame_count); end
        n_checks++; if (pv_cnt !== 1) begin n_fail++; $display("FAIL nom_probe_pulses2: got %0d, required 1", pv_cnt); end
        n_checks++; if (probe_color !== exp_probe_c) begin n_fail++; $display("FAIL nom_probe_color2: got %0d, required %0d", probe_color, exp_probe_c); end
        n_checks++; if (se_cnt !== 0) begin n_fail++; $display("FAIL nom_sync_error: got %0d pulses, required 0", se_cnt); end
    endtask

    task automatic test_drop_hsync();
        clear_counts();
        run_frame(9, 8, -1, 1'b1);
        n_checks++; if (se_cnt !== 1) begin n_fail++; $display("FAIL drop_se_pulses: got %0d, required 1", se_cnt); end
        n_checks++; if (se_line !== 8) begin n_fail++; $display("FAIL drop_se_line: got %0d, required 8", se_line); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL drop_locked: got %0d, required 0", locked); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL drop_fc: got %0d, required 2", frame_count); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL drop_missing_pixels: got %0d left, required 0", sb.size()); end
        run_frame(2, -1, -1, 1'b0);
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL drop_fc_held: got %0d, required 2", frame_count); end
        n_checks++; if (se_cnt !== 1) begin n_fail++; $display("FAIL drop_se_once: got %0d, required 1", se_cnt); end
    endtask

    task automatic test_long_line();
        clear_counts();
        run_frame(1, -1, 4, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL long_locked_b: got %0d, required 0", locked); end
        run_frame(2, -1, -1, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL long_locked_c: got %0d, required 0", locked); end
        run_frame(3, -1, -1, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL long_locked_d: got %0d, required 0", locked); end
        run_line(0, HT, 1'b0, 4, 1'b1);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL long_relock: got %0d, required 1", locked); end
        for (int l = 1; l < VT; l++) run_line(l, HT, 1'b0, 4, 1'b1);
        n_checks++; if (de_cnt !== HD * VD) begin n_fail++; $display("FAIL long_de_count: got %0d, required %0d", de_cnt, HD * VD); end
        n_checks++; if (se_cnt !== 0) begin n_fail++; $display("FAIL long_sync_error: got %0d, required 0", se_cnt); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL long_fc: got %0d, required 2", frame_count); end
    endtask

    task automatic test_reset_mid_line();
        run_line(0, HT, 1'b0, 3, 1'b1);
        run_line(1, HD, 1'b0, 3, 1'b1);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_locked: got %0d, required 1", locked); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %0d, required 0", locked); end
        n_checks++; if ({h_period, v_period} !== 20'd0) begin n_fail++; $display("FAIL midrst_periods: got %0d/%0d, required 0/0", h_period, v_period); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL midrst_fc: got %0d, required 0", frame_count); end
        n_checks++; if (probe_color !== 6'd0) begin n_fail++; $display("FAIL midrst_probe_color: got %0d, required 0", probe_color); end
        n_checks++; if ({de, pix_x, pix_y, rgb_out, probe_valid, sync_error} !== 29'd0) begin n_fail++; $display("FAIL midrst_misc: got %0h, required 0", {de, pix_x, pix_y, rgb_out, probe_valid, sync_error}); end
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b1;
        tick();
        clear_counts();
        run_frame(6, -1, -1, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked_r1: got %0d, required 0", locked); end
        run_frame(7, -1, -1, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked_r2: got %0d, required 0", locked); end
        run_line(0, HT, 1'b0, 8, 1'b1);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL midrst_relock: got %0d, required 1", locked); end
        for (int l = 1; l < VT; l++) run_line(l, HT, 1'b0, 8, 1'b1);
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL midrst_missing_pixels: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_wrap();
        probe_x = 10'd700;
        probe_y = 10'd10;
        clear_counts();
        for (int k = 1; k <= 256; k++) begin
            run_frame(k, -1, -1, 1'b1);
            if (k == 255) begin
                n_checks++; if (frame_count !== 8'd255) begin n_fail++; $display("FAIL wrap_fc255: got %0d, required 255", frame_count); end
            end
        end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL wrap_fc0: got %0d, required 0", frame_count); end
        n_checks++; if (pv_cnt !== 0) begin n_fail++; $display("FAIL wrap_probe_out_of_range: got %0d pulses, required 0", pv_cnt); end
        n_checks++; if (de_cnt !== 256 * HD * VD) begin n_fail++; $display("FAIL wrap_de_count: got %0d, required %0d", de_cnt, 256 * HD * VD); end
        n_checks++; if (se_cnt !== 0) begin n_fail++; $display("FAIL wrap_sync_error: got %0d, required 0", se_cnt); end
    endtask

    initial begin
        rst_n    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        rgb_in   = 6'd0;
        probe_x  = 10'd0;
        probe_y  = 10'd0;
        for (int i = 0; i < 3; i++) tick();
        test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL idle_locked: got %0d, required 0", locked); end
        test_nominal();
        test_drop_hsync();
        test_long_line();
        test_reset_mid_line();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
